// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 16-bit Harvard core: opcode constants (also used
// by the opcode decoder), the sequencer state encoding and the pc_src mux
// select encodings.
package cpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] PC_SRC_NEXT   = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } seq_state_t;

  // Loads and stores are the only instructions that visit the MEM state.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts the cycles a memory request has been waiting for its ack and flags
// expiry on the last permitted cycle. Only one request is ever outstanding, so
// a single counter serves both instruction and data memory.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset
//   active  a request is currently outstanding
//   ack     the ack matching the outstanding request
//   expire  this is the final wait cycle and no ack arrived
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count_q;

  // The counter sits at zero whenever no request is pending, so every entry
  // into a waiting state starts a fresh count. An ack also clears it, which
  // covers back-to-back requests (MEM straight into FETCH).
  always_ff @(posedge clk) begin
    if (reset || !active || ack) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 8'd1;
    end
  end

  // An ack on the final cycle wins over the timeout.
  assign expire = active && !ack && (count_q == LAST_WAIT);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB, handshakes with imem/dmem and produces the
// per-cycle datapath enables. Requests that see no ack within MEM_TIMEOUT
// cycles set the sticky err flag and park the sequencer in HALT.
// Parameters: MEM_TIMEOUT (1..255 wait cycles), CNT_W (perf counter width).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   run                        permit new instruction fetches
//   instr                      imem word, opcode in instr[15:13]
//   imem_req / imem_ack        instruction fetch handshake
//   dmem_req / dmem_we / ack   data access handshake, dmem_we=1 for stores
//   zero                       ALU zero flag, used by beq in EXEC
//   ir_we, alu_en, reg_we      IR load, ALU result load, regfile write
//   pc_we, pc_src              PC update strobe and next-PC select
//   halted, err                in HALT, sticky memory-timeout flag
//   cycle_cnt, retired_cnt     performance counters
// Configuration macro: SEQ_PERF_COUNT_EN enables the performance counters;
// when undefined both counter ports read 0 and no counter logic is built.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      instr,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             zero,
  output logic             ir_we,
  output logic             alu_en,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  seq_state_t state_q, state_d;
  logic [2:0] opcode_q;
  logic       err_q;
  logic       wait_active;
  logic       wait_ack;
  logic       wait_expire;
  logic       unused_instr_bits;

  // Only the opcode field matters here; the rest of the word feeds the datapath.
  assign unused_instr_bits = ^instr[12:0];

  // Timer inputs come straight from the state register so the timer never
  // forms a loop with the next-state logic that consumes its expire flag.
  assign wait_active = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wait_ack    = (state_q == S_FETCH) ? imem_ack :
                       (state_q == S_MEM)   ? dmem_ack : 1'b0;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .active (wait_active),
    .ack    (wait_ack),
    .expire (wait_expire)
  );

  // State, latched opcode and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_ADD;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_we) begin
        opcode_q <= instr[15:13];
      end
      if (wait_expire) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next-state and strobe generation. The ack-qualified strobes are Mealy so
  // a zero-wait access completes in its first request cycle.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    alu_en   = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_SRC_NEXT;
    halted   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expire) begin
          state_d = S_HALT;
        end
      end

      S_DECODE: begin
        state_d = (opcode_q == OP_HALT) ? S_HALT : S_EXEC;
      end

      S_EXEC: begin
        alu_en = 1'b1;
        if (is_mem_op(opcode_q)) begin
          state_d = S_MEM;
        end else if ((opcode_q == OP_BEQ) || (opcode_q == OP_JMP)) begin
          pc_we = 1'b1;
          if (opcode_q == OP_JMP) begin
            pc_src = PC_SRC_JUMP;
          end else if (zero) begin
            pc_src = PC_SRC_BRANCH;
          end
          state_d = run ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode_q == OP_SW);
        if (dmem_ack) begin
          if (opcode_q == OP_SW) begin
            pc_we   = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expire) begin
          state_d = S_HALT;
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A reset in progress cancels any pending access at once rather than
    // letting it complete on the reset edge.
    if (reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      alu_en   = 1'b0;
      reg_we   = 1'b0;
      pc_we    = 1'b0;
      pc_src   = PC_SRC_NEXT;
    end
  end

  assign err = err_q;

`ifdef SEQ_PERF_COUNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] retired_q;

  // Active cycles are those spent anywhere but IDLE or HALT; every PC update
  // marks exactly one retired instruction. Both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      if ((state_q != S_IDLE) && (state_q != S_HALT)) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (pc_we) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Directed bench for cpu_sequencer. Inputs change just after the falling
// edge and outputs are compared 1 time unit later, well away from the
// rising edge. Expected strobe sets are composed from the bit constants below.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        zero;
  logic        ir_we;
  logic        alu_en;
  logic        reg_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        halted;
  logic        err;
  logic [31:0] cycle_cnt;
  logic [31:0] retired_cnt;

  int vectors    = 0;
  int miscompares = 0;

  // Output bundle: {imem_req,dmem_req,dmem_we,ir_we,alu_en,reg_we,pc_we,pc_src,halted,err}
  localparam logic [10:0] B_IREQ = 11'b100_0000_0000;
  localparam logic [10:0] B_DREQ = 11'b010_0000_0000;
  localparam logic [10:0] B_DWE  = 11'b001_0000_0000;
  localparam logic [10:0] B_IRWE = 11'b000_1000_0000;
  localparam logic [10:0] B_ALU  = 11'b000_0100_0000;
  localparam logic [10:0] B_RWE  = 11'b000_0010_0000;
  localparam logic [10:0] B_PCWE = 11'b000_0001_0000;
  localparam logic [10:0] B_BR   = 11'b000_0000_0100;
  localparam logic [10:0] B_JMP  = 11'b000_0000_1000;
  localparam logic [10:0] B_HALT = 11'b000_0000_0010;
  localparam logic [10:0] B_ERR  = 11'b000_0000_0001;

  localparam logic [10:0] E_NONE  = 11'b0;
  localparam logic [10:0] E_FACK  = B_IREQ | B_IRWE;
  localparam logic [10:0] E_EXEC  = B_ALU;
  localparam logic [10:0] E_WB    = B_RWE | B_PCWE;
  localparam logic [10:0] E_MRD   = B_DREQ;
  localparam logic [10:0] E_MWR   = B_DREQ | B_DWE;
  localparam logic [10:0] E_SWACK = B_DREQ | B_DWE | B_PCWE;
  localparam logic [10:0] E_BEQT  = B_ALU | B_PCWE | B_BR;
  localparam logic [10:0] E_BEQN  = B_ALU | B_PCWE;
  localparam logic [10:0] E_JMPX  = B_ALU | B_PCWE | B_JMP;

  cpu_sequencer #(
    .MEM_TIMEOUT(15),
    .CNT_W(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instr       (instr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .zero        (zero),
    .ir_we       (ir_we),
    .alu_en      (alu_en),
    .reg_we      (reg_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .halted      (halted),
    .err         (err),
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs and let the combinational outputs settle.
  task automatic applyStimulus(input logic r, input logic ia, input logic da,
                               input logic z, input logic [15:0] ins);
    run      = r;
    imem_ack = ia;
    dmem_ack = da;
    zero     = z;
    instr    = ins;
    #1;
  endtask

  // Compare the whole strobe bundle against its hand-derived value.
  task automatic checkOutput(input string tag, input logic [10:0] expected);
    logic [10:0] observed;
    observed = {imem_req, dmem_req, dmem_we, ir_we, alu_en, reg_we, pc_we,
                pc_src, halted, err};
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One full cycle: drive, check, advance to the next falling edge.
  task automatic runCycle(input logic r, input logic ia, input logic da,
                          input logic z, input logic [15:0] ins,
                          input string tag, input logic [10:0] expected);
    applyStimulus(r, ia, da, z, ins);
    checkOutput(tag, expected);
    @(negedge clk);
  endtask

  // Hold reset across one rising edge and verify everything is cleared.
  task automatic doReset(input string tag);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput(tag, E_NONE);
    checkValue({tag, ".cycles"}, cycle_cnt, 32'd0);
    checkValue({tag, ".retired"}, retired_cnt, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    run      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    zero     = 1'b0;
    instr    = 16'h0000;
    @(negedge clk);

    $display("[TB] reset and add, zero wait");
    doReset("rst");
    runCycle(1, 0, 0, 0, 16'h0000, "add.idle",   E_NONE);
    runCycle(1, 1, 0, 0, 16'h0000, "add.fetch",  E_FACK);
    runCycle(1, 0, 0, 0, 16'h0000, "add.decode", E_NONE);
    runCycle(1, 0, 0, 0, 16'h0000, "add.exec",   E_EXEC);
    runCycle(1, 0, 0, 0, 16'h0000, "add.wb",     E_WB);

    $display("[TB] lw with two dmem wait cycles, stray acks ignored");
    runCycle(1, 1, 0, 0, 16'h6000, "lw.fetch",  E_FACK);
    runCycle(1, 0, 1, 0, 16'h0000, "lw.decode", E_NONE);
    runCycle(1, 0, 1, 0, 16'h0000, "lw.exec",   E_EXEC);
    runCycle(1, 0, 0, 0, 16'h0000, "lw.mem0",   E_MRD);
    runCycle(1, 0, 0, 0, 16'h0000, "lw.mem1",   E_MRD);
    runCycle(1, 0, 1, 0, 16'h0000, "lw.mem2",   E_MRD);
    runCycle(1, 0, 0, 0, 16'h0000, "lw.wb",     E_WB);

    $display("[TB] beq taken and not taken");
    runCycle(1, 1, 0, 0, 16'hA000, "beqT.fetch",  E_FACK);
    runCycle(1, 0, 0, 0, 16'h0000, "beqT.decode", E_NONE);
    runCycle(1, 0, 0, 1, 16'h0000, "beqT.exec",   E_BEQT);
    runCycle(1, 1, 0, 0, 16'hA000, "beqN.fetch",  E_FACK);
    runCycle(1, 0, 0, 1, 16'h0000, "beqN.decode", E_NONE);
    runCycle(1, 0, 0, 0, 16'h0000, "beqN.exec",   E_BEQN);

    $display("[TB] jmp with one fetch wait");
    runCycle(1, 0, 0, 0, 16'h0000, "jmp.fwait",  B_IREQ);
    runCycle(1, 1, 0, 0, 16'hC000, "jmp.fetch",  E_FACK);
    runCycle(1, 0, 0, 0, 16'h0000, "jmp.decode", E_NONE);
    runCycle(1, 0, 0, 0, 16'h0000, "jmp.exec",   E_JMPX);

    $display("[TB] sw with run dropped during MEM");
    runCycle(1, 1, 0, 0, 16'h8000, "sw.fetch",  E_FACK);
    runCycle(1, 0, 0, 0, 16'h0000, "sw.decode", E_NONE);
    runCycle(1, 0, 0, 0, 16'h0000, "sw.exec",   E_EXEC);
    runCycle(0, 0, 0, 0, 16'h0000, "sw.mem0",   E_MWR);
    runCycle(0, 0, 1, 0, 16'h0000, "sw.mem1",   E_SWACK);
    runCycle(0, 1, 0, 0, 16'h0000, "sw.idle0",  E_NONE);
    runCycle(0, 0, 0, 0, 16'h0000, "sw.idle1",  E_NONE);
`ifdef SEQ_PERF_COUNT_EN
    checkValue("mix.cycles",  cycle_cnt,   32'd26);
    checkValue("mix.retired", retired_cnt, 32'd6);
`else
    checkValue("mix.cycles",  cycle_cnt,   32'd0);
    checkValue("mix.retired", retired_cnt, 32'd0);
`endif

    $display("[TB] counters over three adds");
    doReset("cnt.rst");
    runCycle(1, 0, 0, 0, 16'h0000, "cnt.idle", E_NONE);
    for (int i = 0; i < 3; i++) begin
      runCycle(1, 1, 0, 0, 16'h0000, "cnt.fetch",  E_FACK);
      runCycle(1, 0, 0, 0, 16'h0000, "cnt.decode", E_NONE);
      runCycle(1, 0, 0, 0, 16'h0000, "cnt.exec",   E_EXEC);
      runCycle((i < 2) ? 1'b1 : 1'b0, 0, 0, 0, 16'h0000, "cnt.wb", E_WB);
    end
    runCycle(0, 0, 0, 0, 16'h0000, "cnt.idle2", E_NONE);
`ifdef SEQ_PERF_COUNT_EN
    checkValue("cnt.cycles",  cycle_cnt,   32'd12);
    checkValue("cnt.retired", retired_cnt, 32'd3);
`else
    checkValue("cnt.cycles",  cycle_cnt,   32'd0);
    checkValue("cnt.retired", retired_cnt, 32'd0);
`endif

    $display("[TB] imem timeout");
    doReset("ito.rst");
    runCycle(1, 0, 0, 0, 16'h0000, "ito.idle", E_NONE);
    for (int i = 0; i < 15; i++) begin
      runCycle(1, 0, 0, 0, 16'h0000, "ito.wait", B_IREQ);
    end
    runCycle(1, 1, 0, 0, 16'h0000, "ito.halt", B_HALT | B_ERR);
    runCycle(1, 0, 0, 0, 16'h0000, "ito.stay", B_HALT | B_ERR);

    $display("[TB] imem ack on the last permitted cycle");
    doReset("iack.rst");
    runCycle(1, 0, 0, 0, 16'h0000, "iack.idle", E_NONE);
    for (int i = 0; i < 14; i++) begin
      runCycle(1, 0, 0, 0, 16'h0000, "iack.wait", B_IREQ);
    end
    runCycle(1, 1, 0, 0, 16'h0000, "iack.fetch",  E_FACK);
    runCycle(1, 0, 0, 0, 16'h0000, "iack.decode", E_NONE);
    runCycle(1, 0, 0, 0, 16'h0000, "iack.exec",   E_EXEC);
    runCycle(1, 0, 0, 0, 16'h0000, "iack.wb",     E_WB);

    $display("[TB] halt instruction");
    runCycle(1, 1, 0, 0, 16'hE000, "halt.fetch",  E_FACK);
    runCycle(1, 0, 0, 0, 16'h0000, "halt.decode", E_NONE);
    for (int i = 0; i < 3; i++) begin
      runCycle(1, 1, 1, 1, 16'h0000, "halt.stay", B_HALT);
    end
    doReset("halt.rst");

    $display("[TB] dmem timeout");
    runCycle(1, 0, 0, 0, 16'h0000, "dto.idle",   E_NONE);
    runCycle(1, 1, 0, 0, 16'h6000, "dto.fetch",  E_FACK);
    runCycle(1, 0, 0, 0, 16'h0000, "dto.decode", E_NONE);
    runCycle(1, 0, 0, 0, 16'h0000, "dto.exec",   E_EXEC);
    for (int i = 0; i < 15; i++) begin
      runCycle(1, 0, 0, 0, 16'h0000, "dto.wait", E_MRD);
    end
    runCycle(1, 0, 1, 0, 16'h0000, "dto.halt", B_HALT | B_ERR);

    $display("[TB] reset during a fetch");
    doReset("mid.rst");
    runCycle(1, 0, 0, 0, 16'h0000, "mid.idle", E_NONE);
    reset = 1'b1;
    applyStimulus(1, 1, 0, 0, 16'h0000);
    checkOutput("mid.fetch", E_NONE);
    @(negedge clk);
    reset = 1'b0;
    runCycle(0, 1, 0, 0, 16'h0000, "mid.after", E_NONE);
    runCycle(1, 0, 0, 0, 16'h0000, "mid.idle2", E_NONE);
    runCycle(1, 0, 0, 0, 16'h0000, "mid.refetch", B_IREQ);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 16-bit Harvard core. It steps each instruction through fetch, decode, execute, memory and write-back, and handshakes with instruction and data memory. It produces the per-cycle enables that the datapath (PC, IR, register file, ALU, data memory) needs. It sits beside the opcode decoder: the decoder supplies static control levels, and this block decides *when* they take effect.

## Interface
- `MEM_TIMEOUT`, 15: maximum wait cycles for any memory ack before error (1..255).
- `CNT_W`, 32: width of performance counters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `run`  in  1  permit new instruction fetches.
- `instr`  in  16  instruction word from imem, valid with `imem_ack`; opcode is `instr[15:13]`.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch complete.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  write (1) or read (0); valid with `dmem_req`.
- `dmem_ack`  in  1  data access complete.
- `zero`  in  1  ALU zero flag, sampled in EXEC.
- `ir_we`  out  1  IR load strobe.
- `alu_en`  out  1  ALU result register load.
- `reg_we`  out  1  register-file write strobe.
- `pc_we`  out  1  PC update strobe.
- `pc_src`  out  2  00 = pc+1, 01 = pc+1+offset, 10 = jump target.
- `halted`  out  1  in HALT state.
- `err`  out  1  sticky memory-timeout flag.
- `cycle_cnt`  out  CNT_W  active-cycle count.
- `retired_cnt`  out  CNT_W  retired-instruction count.

## Operation
- Opcodes:
  - 000 add
  - 001 sub
  - 010 addi
  - 011 lw
  - 100 sw
  - 101 beq
  - 110 jmp
  - 111 halt
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. The opcode is latched internally on `ir_we`.
- IDLE: go to FETCH when `run`=1.
- FETCH: `imem_req`=1. When `imem_ack`=1, pulse `ir_we` and go to DECODE.
- DECODE: one cycle. Opcode 111 goes to HALT; all others go to EXEC.
- EXEC:
  - `alu_en`=1.
  - add/sub/addi go to WB.
  - lw/sw go to MEM.
  - beq/jmp retire here: `pc_we`=1, `pc_src`=01 if beq and `zero`, 10 for jmp, else 00.
- MEM:
  - `dmem_req`=1, with `dmem_we`=1 for sw.
  - On `dmem_ack`: lw goes to WB; sw retires (`pc_we`=1, `pc_src`=00).
- WB: `reg_we`=1, `pc_we`=1, `pc_src`=00; the instruction retires.
- After retire: go to FETCH if `run`=1, else IDLE. Deasserting `run` mid-instruction never aborts it.
- HALT: all strobes 0, `halted`=1. Only `reset` exits HALT.
- Timeout:
  - The wait counter clears on entering FETCH or MEM and increments each cycle without ack.
  - When it reaches `MEM_TIMEOUT`, drop the request, set `err`=1 and go to HALT.
  - Ack in the same cycle as the timeout wins: no error.
- Acks arriving while the matching request is low are ignored.
- Strobes (`ir_we`, `alu_en`, `reg_we`, `pc_we`) are single-cycle per state visit.

## Timing
- Outputs are combinational from state plus ack/zero (Mealy for the ack-qualified strobes). State and counters are registered.
- Reset values: state IDLE; every output 0, including `err`, `halted` and the counters.
- A `reset` asserted mid-operation takes effect at the next edge. Requests drop immediately, with no completion of a pending access.
- Zero-wait latency (ack in the first request cycle):
  - add/sub/addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/jmp: 3 cycles
  - halt: 2 cycles to HALT
- Each wait cycle adds 1.
- `imem_req`/`dmem_req` stay high continuously until ack or timeout.

## Configuration
- `SEQ_PERF_COUNT_EN` defined:
  - `cycle_cnt` increments every cycle outside IDLE/HALT.
  - `retired_cnt` increments on each `pc_we`.
  - Both wrap modulo 2^CNT_W.
- `SEQ_PERF_COUNT_EN` undefined: both ports are tied to 0 and the counter logic is absent.

## Structure
- Shared package `cpu_pkg`: opcode constants, sequencer state enum, and `pc_src` encodings. The opcode decoder uses the same opcode constants.
- One sub-module, `mem_wait_timer`, holds the clear/count/expire logic and is instanced once. Only one request is ever outstanding.

## Test plan
- Add, zero-wait: `run`=1, `imem_ack` on first request, instr 0x0000 -> `ir_we` at cycle 1; `reg_we` and `pc_we` with `pc_src`=00 at cycle 4; FETCH at cycle 5.
- lw with 2 dmem wait cycles: instr 0x6000 -> `dmem_req` high for 3 cycles, `dmem_we`=0, `reg_we` 1 cycle after ack, total 7 cycles.
- beq: instr 0xA000 with `zero`=1 -> `pc_src`=01; with `zero`=0 -> `pc_src`=00; `pc_we` in EXEC either way.
- Timeout: `MEM_TIMEOUT`=15, `imem_ack` never asserted -> `imem_req` high 15 cycles, then `err`=1, `halted`=1. Ack on the 15th cycle instead -> no error.
- Halt and run control: instr 0xE000 -> `halted`=1 after 2 cycles; stays halted until `reset`. `run` dropped during MEM of sw -> sw retires, then IDLE.
- Counters (macro on): 3 add instructions -> `retired_cnt`=3, `cycle_cnt`=12; reset clears both.
